// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Define MDU_DIV_EN to build the div/divu datapath; without it those opcodes act as reserved.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [2:0]  i_MDUOp,
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
    input  logic        i_HIWr,
    input  logic        i_LOWr,
    input  logic        i_HILOSel,
    output logic        o_busy,
    output logic [31:0] o_HI,
    output logic [31:0] o_LO,
    output logic [31:0] o_MDOut
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_HI;
    logic [31:0]        r_LO;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_signed;
    logic               w_opValid;
    logic               w_launch;
    logic               w_finish;
    logic [CNT_W-1:0]   w_loadCnt;
    logic [63:0]        w_ma;
    logic [63:0]        w_mb;
    logic [63:0]        w_prod;
    logic [31:0]        w_resHI;
    logic [31:0]        w_resLO;
    logic               w_resWr;

    // Opcode decode: 1xx is always reserved, 01x only when the divider exists.
    always_comb begin
        w_loadCnt = CNT_W'(MULT_CYCLES);
`ifdef MDU_DIV_EN
        w_opValid = ~i_MDUOp[2];
        if (i_MDUOp[1]) begin
            w_loadCnt = CNT_W'(DIV_CYCLES);
        end
`else
        w_opValid = ~i_MDUOp[2] & ~i_MDUOp[1];
`endif
    end

    always_comb begin
        w_nextState = r_state;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_opValid) begin
                    w_launch    = 1'b1;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_finish    = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // One shared multiplier: the low 64 bits of the extended product are correct for both signednesses.
    always_comb begin
        w_ma   = {{32{r_signed & r_a[31]}}, r_a};
        w_mb   = {{32{r_signed & r_b[31]}}, r_b};
        w_prod = w_ma * w_mb;
    end

`ifdef MDU_DIV_EN
    logic        r_isDiv;
    logic        r_divZero;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_negQ;
    logic        w_negR;

    // Sign-magnitude division; 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    always_comb begin
        w_negR = r_signed & r_a[31];
        w_negQ = r_signed & (r_a[31] ^ r_b[31]);
        w_absA = w_negR ? -r_a : r_a;
        w_absB = (r_signed & r_b[31]) ? -r_b : r_b;
        w_uq   = '0;
        w_ur   = '0;
        if (!r_divZero) begin
            w_uq = w_absA / w_absB;
            w_ur = w_absA % w_absB;
        end
        w_resLO = r_isDiv ? (w_negQ ? -w_uq : w_uq) : w_prod[31:0];
        w_resHI = r_isDiv ? (w_negR ? -w_ur : w_ur) : w_prod[63:32];
        w_resWr = ~(r_isDiv & r_divZero);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
        end else if (w_launch) begin
            r_isDiv   <= i_MDUOp[1];
            r_divZero <= i_MDUOp[1] & (i_B == 32'd0);
        end
    end
`else
    always_comb begin
        w_resLO = w_prod[31:0];
        w_resHI = w_prod[63:32];
        w_resWr = 1'b1;
    end
`endif

    // Moves are accepted only in IDLE and only when no start is presented.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_HI     <= '0;
            r_LO     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_launch) begin
                r_a      <= i_A;
                r_b      <= i_B;
                r_signed <= ~i_MDUOp[0];
                r_cnt    <= w_loadCnt;
                r_busy   <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_finish) begin
                    r_busy <= 1'b0;
                    if (w_resWr) begin
                        r_HI <= w_resHI;
                        r_LO <= w_resLO;
                    end
                end
            end else if (!i_start) begin
                if (i_HIWr) begin
                    r_HI <= i_A;
                end
                if (i_LOWr) begin
                    r_LO <= i_A;
                end
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_HI    = r_HI;
    assign o_LO    = r_LO;
    assign o_MDOut = i_HILOSel ? r_HI : r_LO;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit; div checks follow whether MDU_DIV_EN is defined.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [2:0]  mduOp;
    logic [31:0] a;
    logic [31:0] b;
    logic        hiWr;
    logic        loWr;
    logic        hiloSel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdOut;

    int checks   = 0;
    int failures = 0;
    int nBusy;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk     (clk),
        .i_reset_n (resetN),
        .i_start   (start),
        .i_MDUOp   (mduOp),
        .i_A       (a),
        .i_B       (b),
        .i_HIWr    (hiWr),
        .i_LOWr    (loWr),
        .i_HILOSel (hiloSel),
        .o_busy    (busy),
        .o_HI      (hi),
        .o_LO      (lo),
        .o_MDOut   (mdOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a start for one edge, then scrambles the operands to prove they were latched.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        mduOp = op;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        a     = 32'h5A5A_1234;
        b     = 32'h0F0F_8765;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        resetN  = 1'b0;
        start   = 1'b0;
        mduOp   = 3'b000;
        a       = '0;
        b       = '0;
        hiWr    = 1'b0;
        loWr    = 1'b0;
        hiloSel = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        applyStimulus(3'b000, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_busy_rise", {31'd0, busy}, 32'd1);
        waitDone(nBusy);
        checkOutput("mult_cycles", nBusy, 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(nBusy);
        checkOutput("multu_cycles", nBusy, 32'd5);
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);

        hiWr = 1'b1;
        a    = 32'h1234_5678;
        @(negedge clk);
        hiWr    = 1'b0;
        hiloSel = 1'b1;
        #1;
        checkOutput("mfhi", mdOut, 32'h1234_5678);
        hiloSel = 1'b0;
        #1;
        checkOutput("mflo", mdOut, 32'h0000_0001);

        hiWr = 1'b1;
        loWr = 1'b1;
        a    = 32'hCAFE_F00D;
        @(negedge clk);
        hiWr = 1'b0;
        loWr = 1'b0;
        checkOutput("mthilo_hi", hi, 32'hCAFE_F00D);
        checkOutput("mthilo_lo", lo, 32'hCAFE_F00D);

`ifdef MDU_DIV_EN
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
        waitDone(nBusy);
        checkOutput("div_cycles", nBusy, 32'd10);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);

        applyStimulus(3'b011, 32'd7, 32'd0);
        waitDone(nBusy);
        checkOutput("divz_cycles", nBusy, 32'd10);
        checkOutput("divz_lo", lo, 32'hFFFF_FFFD);
        checkOutput("divz_hi", hi, 32'hFFFF_FFFF);

        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(nBusy);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        checkOutput("divovf_hi", hi, 32'h0000_0000);

        applyStimulus(3'b011, 32'd100, 32'd7);
        waitDone(nBusy);
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);
`else
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
        checkOutput("nodiv_busy", {31'd0, busy}, 32'd0);
        repeat (11) @(negedge clk);
        checkOutput("nodiv_busy_late", {31'd0, busy}, 32'd0);
        checkOutput("nodiv_hi", hi, 32'hCAFE_F00D);
        checkOutput("nodiv_lo", lo, 32'hCAFE_F00D);
`endif

        applyStimulus(3'b100, 32'd9, 32'd9);
        checkOutput("rsvd_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("rsvd_busy_late", {31'd0, busy}, 32'd0);

        applyStimulus(3'b000, 32'd3, 32'd4);
        start = 1'b1;
        mduOp = 3'b001;
        hiWr  = 1'b1;
        a     = 32'hDEAD_BEEF;
        b     = 32'h7777_7777;
        @(negedge clk);
        start = 1'b0;
        hiWr  = 1'b0;
        waitDone(nBusy);
        checkOutput("ignore_cycles", nBusy, 32'd4);
        checkOutput("ignore_hi", hi, 32'd0);
        checkOutput("ignore_lo", lo, 32'd12);

        hiWr = 1'b1;
        applyStimulus(3'b000, 32'd5, 32'd6);
        hiWr = 1'b0;
        waitDone(nBusy);
        checkOutput("startwins_hi", hi, 32'd0);
        checkOutput("startwins_lo", lo, 32'd30);

        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(nBusy);
        checkOutput("b2b_cycles", nBusy, 32'd5);
        checkOutput("b2b_lo", lo, 32'd1);

        applyStimulus(3'b000, 32'd2, 32'd2);
        repeat (2) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("rst_nolate_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_nolate_lo", lo, 32'd0);
        checkOutput("rst_nolate_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
